// File: rtl/jtopl_pkg.sv
// Shared constants and address decode for the OPL channel scheduler.
// Register addresses, frame geometry and rhythm bit positions live here.
package jtopl_pkg;

    localparam logic [7:0] ADDR_FNUMLO = 8'hA0;
    localparam logic [7:0] ADDR_FNUMHI = 8'hB0;
    localparam logic [7:0] ADDR_FBCON  = 8'hC0;
    localparam logic [7:0] ADDR_RHY    = 8'hBD;

    localparam int NCH   = 9;
    localparam int NSLOT = 18;

    localparam int RHY_BD  = 4;
    localparam int RHY_SD  = 3;
    localparam int RHY_TOM = 2;
    localparam int RHY_TC  = 1;
    localparam int RHY_HH  = 0;

    typedef enum logic [2:0] {
        DEC_NONE,
        DEC_FNUMLO,
        DEC_FNUMHI,
        DEC_FBCON,
        DEC_RHY
    } dec_e;

    // Each per-channel bank covers base..base+8; the unused tail of a bank decodes to nothing.
    function automatic dec_e decode(input logic [7:0] a);
        dec_e d;
        d = DEC_NONE;
        if (a == ADDR_RHY)
            d = DEC_RHY;
        else if (a[3:0] < 4'(NCH)) begin
            if (a[7:4] == ADDR_FNUMLO[7:4])
                d = DEC_FNUMLO;
            else if (a[7:4] == ADDR_FNUMHI[7:4])
                d = DEC_FNUMHI;
            else if (a[7:4] == ADDR_FBCON[7:4])
                d = DEC_FBCON;
        end
        return d;
    endfunction

endpackage

// File: rtl/jtopl_ch_sched_if.sv
// CPU write bus seen by the channel scheduler: chip select, write strobe,
// address/data select, data byte and the busy flag returned to the CPU side.
interface jtopl_ch_sched_if;

    logic       cs_n;
    logic       wr_n;
    logic       addr;
    logic [7:0] din;
    logic       busy;

    modport master (
        output cs_n,
        output wr_n,
        output addr,
        output din,
        input  busy
    );

    modport slave (
        input  cs_n,
        input  wr_n,
        input  addr,
        input  din,
        output busy
    );

endinterface

// File: rtl/jtopl_slot_cnt.sv
// Operator slot sequencer: 3 groups of 6 sub-slots, advancing once per cen,
// with combinational one-hot slot and frame-start (zero) decode.
module jtopl_slot_cnt #(
    parameter int NSLOT = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    output logic [1:0]       group,
    output logic [2:0]       sub,
    output logic [NSLOT-1:0] slot,
    output logic             zero
);

    logic [4:0] idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            group <= 2'd0;
            sub   <= 3'd0;
        end else if (cen) begin
            if (sub == 3'd5) begin
                sub   <= 3'd0;
                group <= (group == 2'd2) ? 2'd0 : group + 2'd1;
            end else begin
                sub <= sub + 3'd1;
            end
        end
    end

    always_comb begin
        idx  = 5'(group) * 5'd6 + 5'(sub);
        slot = {{(NSLOT-1){1'b0}}, 1'b1} << idx;
        zero = (group == 2'd0) && (sub == 3'd0);
    end

endmodule

// File: rtl/jtopl_ch_sched.sv
// Channel scheduler: slot sequencing plus serialisation of CPU register
// writes into single-cycle channel update strobes and rhythm controls.
module jtopl_ch_sched #(
    parameter int NSLOT = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cen,
    jtopl_ch_sched_if.slave      cpu,
    output logic [1:0]           group,
    output logic [2:0]           sub,
    output logic [NSLOT-1:0]     slot,
    output logic                 zero,
    output logic [3:0]           up_ch,
    output logic                 up_fnumlo,
    output logic                 up_fnumhi,
    output logic                 up_fbcon,
    output logic [7:0]           dout,
    output logic                 rhy_en,
    output logic [4:0]           rhy_kon
);

    import jtopl_pkg::*;

    logic       wr_now;
    logic       wr_last;
    logic       wr_edge;
    logic       data_cap;
    logic       busy;
    logic [7:0] sel;
    logic [7:0] hold_addr_p0;
    logic [7:0] hold_din_p0;
    dec_e       dec;

    jtopl_slot_cnt #(.NSLOT(NSLOT)) u_slot_cnt (
        .clk   (clk),
        .rst   (rst),
        .cen   (cen),
        .group (group),
        .sub   (sub),
        .slot  (slot),
        .zero  (zero)
    );

    // One write per low pulse regardless of cen; a held-low strobe is not re-accepted.
    assign wr_now   = !cpu.cs_n && !cpu.wr_n;
    assign wr_edge  = wr_now && !wr_last;
    assign data_cap = wr_edge && cpu.addr && !busy;
    assign dec      = decode(hold_addr_p0);
    assign cpu.busy = busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_last   <= 1'b0;
            sel       <= 8'd0;
            busy      <= 1'b0;
            up_fnumlo <= 1'b0;
            up_fnumhi <= 1'b0;
            up_fbcon  <= 1'b0;
            up_ch     <= 4'd0;
            dout      <= 8'd0;
            rhy_en    <= 1'b0;
            rhy_kon   <= 5'd0;
        end else begin
            wr_last   <= wr_now;
            up_fnumlo <= 1'b0;
            up_fnumhi <= 1'b0;
            up_fbcon  <= 1'b0;
            if (wr_edge && !cpu.addr)
                sel <= cpu.din;
            // Issue takes priority: a data write arriving in the issue cycle sees busy and is lost.
            if (cen && busy) begin
                busy <= 1'b0;
                case (dec)
                    DEC_FNUMLO: begin
                        up_fnumlo <= 1'b1;
                        up_ch     <= hold_addr_p0[3:0];
                        dout      <= hold_din_p0;
                    end
                    DEC_FNUMHI: begin
                        up_fnumhi <= 1'b1;
                        up_ch     <= hold_addr_p0[3:0];
                        dout      <= hold_din_p0;
                    end
                    DEC_FBCON: begin
                        up_fbcon <= 1'b1;
                        up_ch    <= hold_addr_p0[3:0];
                        dout     <= hold_din_p0;
                    end
                    DEC_RHY: begin
                        rhy_en  <= hold_din_p0[5];
                        rhy_kon <= hold_din_p0[RHY_BD:RHY_HH];
                    end
                    default: ;
                endcase
            end else if (data_cap) begin
                busy <= 1'b1;
            end
        end
    end

    // Hold register: captured address/data pair waiting for the next cen
    always_ff @(posedge clk) begin
        if (data_cap) begin
            hold_addr_p0 <= sel;
            hold_din_p0  <= cpu.din;
        end
    end

endmodule

// File: tb/tb_jtopl_ch_sched.sv
// Scoreboard bench for jtopl_ch_sched: driver feeds a behavioural model that
// queues expected strobe/rhythm events; a monitor pops and compares them.
module tb_jtopl_ch_sched;

    import jtopl_pkg::*;

    localparam int NS = 18;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cen = 1'b0;
    logic [1:0]    group;
    logic [2:0]    sub;
    logic [NS-1:0] slot;
    logic          zero;
    logic [3:0]    up_ch;
    logic          up_fnumlo, up_fnumhi, up_fbcon;
    logic [7:0]    dout;
    logic          rhy_en;
    logic [4:0]    rhy_kon;

    jtopl_ch_sched_if cpu();

    jtopl_ch_sched #(.NSLOT(NS)) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .cpu       (cpu),
        .group     (group),
        .sub       (sub),
        .slot      (slot),
        .zero      (zero),
        .up_ch     (up_ch),
        .up_fnumlo (up_fnumlo),
        .up_fnumhi (up_fnumhi),
        .up_fbcon  (up_fbcon),
        .dout      (dout),
        .rhy_en    (rhy_en),
        .rhy_kon   (rhy_kon)
    );

    always #5 clk = ~clk;

    // kind: 0 fnumlo, 1 fnumhi, 2 fbcon, 3 rhythm change ({en,kon} in dat)
    typedef struct {
        int kind;
        int ch;
        int dat;
    } ev_t;

    ev_t expq[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    bit  m_pend    = 1'b0;
    int  m_hold_a  = 0;
    int  m_hold_d  = 0;
    int  m_sel     = 0;
    bit  m_prev_wr = 1'b0;
    int  m_rhy     = 0;
    int  cen_mode  = 2;
    int  cen_phase = 0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    endtask

    task automatic fail_now(input string name, input int act);
        n_checks++;
        $display("FAIL %s: got 0x%0h expected no event at %0t", name, act, $time);
    endtask

    function automatic bit next_cen();
        bit c;
        case (cen_mode)
            0: c = ($urandom_range(0, 2) == 0);
            1: begin
                cen_phase = (cen_phase + 1) % 4;
                c = (cen_phase == 0);
            end
            2: c = 1'b1;
            default: c = 1'b0;
        endcase
        return c;
    endfunction

    // What a held register write should do once it reaches the register file
    function automatic void model_issue(input int a, input int d);
        ev_t e;
        int  r;
        e.ch  = 0;
        e.dat = d;
        if (a >= 'hA0 && a <= 'hA8) begin
            e.kind = 0; e.ch = a - 'hA0; expq.push_back(e);
        end else if (a >= 'hB0 && a <= 'hB8) begin
            e.kind = 1; e.ch = a - 'hB0; expq.push_back(e);
        end else if (a >= 'hC0 && a <= 'hC8) begin
            e.kind = 2; e.ch = a - 'hC0; expq.push_back(e);
        end else if (a == 'hBD) begin
            r = d & 'h3F;
            if (r != m_rhy) begin
                e.kind = 3; e.dat = r; expq.push_back(e);
            end
            m_rhy = r;
        end
    endfunction

    task automatic step(input bit r, input bit w, input bit a, input logic [7:0] d);
        bit c;
        bit wr_e;
        bit pend_old;
        @(negedge clk);
        c = next_cen();
        rst      = r;
        cen      = c;
        cpu.cs_n = !w;
        cpu.wr_n = !w;
        cpu.addr = a;
        cpu.din  = d;
        if (r) begin
            m_pend = 1'b0; m_sel = 0; m_prev_wr = 1'b0; m_rhy = 0;
        end else begin
            pend_old = m_pend;
            if (c && m_pend) begin
                model_issue(m_hold_a, m_hold_d);
                m_pend = 1'b0;
            end
            wr_e      = w && !m_prev_wr;
            m_prev_wr = w;
            if (wr_e) begin
                if (!a)
                    m_sel = int'(d);
                else if (!pend_old) begin
                    m_hold_a = m_sel;
                    m_hold_d = int'(d);
                    m_pend   = 1'b1;
                end
            end
        end
    endtask

    task automatic cpu_wr(input bit a, input logic [7:0] d, input int len, input int gap);
        for (int i = 0; i < len; i++) step(1'b0, 1'b1, a, d);
        for (int i = 0; i < gap; i++) step(1'b0, 1'b0, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    // Monitor
    initial begin
        int  ncen;
        int  last_rhy;
        int  cur_rhy;
        int  nstb;
        ev_t e;
        ncen = 0;
        last_rhy = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                ncen = 0;
                last_rhy = 0;
                chk("rst_strobes", {up_fnumlo, up_fnumhi, up_fbcon}, 0);
                chk("rst_up_ch", up_ch, 0);
                chk("rst_dout", dout, 0);
                chk("rst_rhythm", {rhy_en, rhy_kon}, 0);
            end else if (cen) begin
                ncen = (ncen + 1) % NS;
            end
            chk("slot", int'(slot), 1 << ncen);
            chk("zero", zero, (ncen == 0) ? 1 : 0);
            chk("group", group, ncen / 6);
            chk("sub", sub, ncen % 6);
            chk("busy", cpu.busy, m_pend);

            nstb = int'(up_fnumlo) + int'(up_fnumhi) + int'(up_fbcon);
            if (nstb > 0) begin
                chk("strobe_onehot", nstb, 1);
                if (expq.size() == 0)
                    fail_now("unexpected_strobe", {up_fnumlo, up_fnumhi, up_fbcon});
                else begin
                    e = expq.pop_front();
                    chk("strobe_kind", up_fnumhi ? 1 : (up_fbcon ? 2 : (up_fnumlo ? 0 : 7)), e.kind);
                    chk("up_ch", up_ch, e.ch);
                    chk("dout", dout, e.dat);
                end
            end

            cur_rhy = {rhy_en, rhy_kon};
            if (!rst && cur_rhy != last_rhy) begin
                if (expq.size() == 0)
                    fail_now("unexpected_rhythm", cur_rhy);
                else begin
                    e = expq.pop_front();
                    chk("rhythm_kind", 3, e.kind);
                    chk("rhythm_value", cur_rhy, e.dat);
                end
                last_rhy = cur_rhy;
            end
            chk("late_events", expq.size(), 0);
        end
    end

    // Stimulus
    initial begin
        int a;
        cpu.cs_n = 1'b1;
        cpu.wr_n = 1'b1;
        cpu.addr = 1'b0;
        cpu.din  = 8'd0;

        repeat (3) step(1'b1, 1'b0, 1'b0, 8'd0);

        cen_mode = 2;
        idle(NS + 2);

        cen_mode = 1;
        cpu_wr(1'b0, 8'hA3, 1, 1);
        cpu_wr(1'b1, 8'h5A, 1, 1);
        idle(8);

        cen_mode = 3;
        cpu_wr(1'b0, 8'hB8, 1, 1);
        cpu_wr(1'b1, 8'h31, 1, 1);
        cpu_wr(1'b1, 8'hFF, 1, 1);
        cen_mode = 1;
        idle(8);

        cpu_wr(1'b0, 8'hBD, 1, 1);
        cpu_wr(1'b1, 8'h3F, 1, 1);
        idle(8);

        cpu_wr(1'b0, 8'hA9, 1, 1);
        cpu_wr(1'b1, 8'h44, 1, 1);
        idle(8);
        cpu_wr(1'b0, 8'h20, 1, 1);
        cpu_wr(1'b1, 8'h55, 1, 1);
        idle(8);

        // Capture coinciding with cen waits for the following one
        cen_mode = 2;
        cpu_wr(1'b0, 8'hC4, 1, 1);
        cpu_wr(1'b1, 8'h12, 1, 1);
        idle(4);

        // Long low pulse counts as one write
        cen_mode = 3;
        cpu_wr(1'b0, 8'hA0, 1, 1);
        cpu_wr(1'b1, 8'h81, 4, 1);
        cen_mode = 1;
        idle(8);

        // Reset while busy discards the pending write
        cen_mode = 3;
        cpu_wr(1'b0, 8'hA1, 1, 1);
        cpu_wr(1'b1, 8'h77, 1, 0);
        step(1'b1, 1'b0, 1'b0, 8'd0);
        cen_mode = 2;
        idle(10);

        for (int n = 0; n < 300; n++) begin
            cen_mode = $urandom_range(0, 2);
            case ($urandom_range(0, 5))
                0: a = 'hA0 + $urandom_range(0, 8);
                1: a = 'hB0 + $urandom_range(0, 8);
                2: a = 'hC0 + $urandom_range(0, 8);
                3: a = 'hBD;
                4: a = 'hA9 + $urandom_range(0, 6);
                default: a = $urandom_range(0, 255);
            endcase
            cpu_wr(1'b0, 8'(a), 1, $urandom_range(0, 2));
            cpu_wr(1'b1, 8'($urandom_range(0, 255)), $urandom_range(1, 2), $urandom_range(0, 4));
            if ($urandom_range(0, 39) == 0)
                step(1'b1, 1'b0, 1'b0, 8'd0);
        end

        cen_mode = 2;
        idle(30);
        chk("queue_drained", expq.size(), 0);
        chk("final_busy", cpu.busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/jtopl_ch_sched.md
# jtopl_ch_sched

Channel scheduler for the OPL core: generates the 18-slot operator sequence (`group`, `sub`, `slot`, `zero`) that drives channel-register readout, and serialises CPU register writes into the single-cycle `up_*` strobes and rhythm controls consumed by the channel register file. It sits between the CPU bus interface and the channel register file and is the only source of their sequencing and update signals.

## Interface
- `NSLOT`, 18: operator slots per frame; fixed for OPL, exposed for the bench only.
- `clk` input 1: system clock; the only clock.
- `rst` input 1: synchronous reset, active-high.
- `cen` input 1: clock enable; all sequencing advances and strobes issue only in `cen` cycles.
- `cs_n` input 1: chip select, active-low.
- `wr_n` input 1: write strobe, active-low.
- `addr` input 1: 0 selects the address write, 1 selects the data write.
- `din` input 8: CPU data.
- `busy` output 1: a data write is pending; further data writes are dropped.
- `group` output 2: slot group, 0..2.
- `sub` output 3: sub-slot in group, 0..5.
- `slot` output 18: one-hot `group*6+sub`.
- `zero` output 1: high while `group`=0 and `sub`=0.
- `up_ch` output 4: target channel 0..8.
- `up_fnumlo`, `up_fnumhi`, `up_fbcon` output 1 each: update strobes.
- `dout` output 8: data accompanying the strobes.
- `rhy_en` output 1: rhythm mode enable.
- `rhy_kon` output 5: rhythm key-on bits {BD,SD,TOM,TC,HH}.

## Operation
- Write detect: a write is `cs_n`=0 and `wr_n`=0 in the current cycle while it was not in the previous cycle. One write is accepted per low pulse, independent of `cen`.
- Address write: `sel` (8-bit) <= `din`. This is always accepted, including while `busy`.
- Data write while not busy: capture `{sel, din}` into the hold register and set `busy`. A data write while `busy` is dropped with no side effect.
- Decode of the held address, applied at the first `cen` cycle strictly after capture:
  - 0xA0..0xA8: `up_fnumlo`, `up_ch`=sel[3:0].
  - 0xB0..0xB8: `up_fnumhi`.
  - 0xC0..0xC8: `up_fbcon`.
  - 0xBD: `rhy_en`<=din[5] and `rhy_kon`<=din[4:0]; no `up_*` strobe.
  - Any other address, including 0xA9..0xAF and similar: no effect.
  - In every case `busy` clears on that cycle.
- Slot sequencer: on each `cen`, `sub` increments. When `sub`=5 it wraps to 0 and `group` increments. When `group`=2 and `sub`=5, both return to 0.

## Timing
- Reset values:
  - `group`=0, `sub`=0, `slot`=18'h00001, `zero`=1.
  - `busy`=0, `up_*`=0, `up_ch`=0, `dout`=0, `rhy_en`=0, `rhy_kon`=0.
  - `sel`=0; the write-edge history is cleared.
- `slot` and `zero` are combinational from the registered `group` and `sub`; they change in the same cycle as the counters.
- `up_*`, `up_ch` and `dout` are registered. They assert for exactly the one cycle following the decode `cen` edge, which is itself a `cen`-qualified cycle for the register file, and they deassert afterwards. `up_ch` and `dout` hold their last value.
- Latency: a data write captured in cycle t produces its strobe in the cycle after the first `cen` at or after t+1.
- A capture coinciding with a `cen` does not issue in that cen; it waits for the next one.
- When capture and issue fall in the same cycle, issue wins and the new write is dropped (`busy` was still high).
- `rst` mid-operation discards the pending write and restarts the frame at slot 0.
- A full frame is `NSLOT` `cen` pulses; `zero` pulses once per frame.

## Structure
- Package `jtopl_pkg` holds:
  - constants `ADDR_FNUMLO`=8'hA0, `ADDR_FNUMHI`=8'hB0, `ADDR_FBCON`=8'hC0, `ADDR_RHY`=8'hBD;
  - `NCH`=9, `NSLOT`=18;
  - the rhythm bit indices BD=4, SD=3, TOM=2, TC=1, HH=0.
- Sub-module `jtopl_slot_cnt` contains the `group`/`sub` counter with one-hot and `zero` decode. The write path stays in the top.

## Test plan
- Reset, then 18 `cen` pulses -> `slot` walks bit 0..17, `zero` high only at slot 0, and returns to slot 0 on the 18th pulse.
- Address 0xA3, data 0x5A, `cen` every 4th cycle -> one-cycle `up_fnumlo`, `up_ch`=3, `dout`=0x5A; `busy` clears on issue.
- Address 0xB8, data 0x31, then a second data write 0xFF while busy -> a single `up_fnumhi` with `dout`=0x31; the 0xFF write is lost.
- Address 0xBD, data 0x3F -> `rhy_en`=1, `rhy_kon`=5'h1F, no `up_*` strobes.
- Address 0xA9 and 0x20 writes -> `busy` pulses and no strobe or rhythm change.
- `rst` asserted while `busy` -> no strobe ever issues; counters at 0; `busy`=0.
